// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped IO block: TX FIFO at 0x30000,
// halt / FIFO count register at 0x30004, sticky overflow and halt flags.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_LOG   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] CNT_FULL = (FIFO_LOG+1)'(DEPTH);
  localparam logic [FIFO_LOG:0] CNT_AFULL = (FIFO_LOG+1)'(DEPTH - 2);

  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] fifo [DEPTH];

  logic [FIFO_LOG-1:0] rd_ptr;
  logic [FIFO_LOG-1:0] wr_ptr;
  logic [FIFO_LOG:0]   count;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic io_sel;
  logic tx_sel;
  logic stat_sel;
  logic fifo_full;
  logic push_req;
  logic push;
  logic pop;
  logic [7:0] stat_byte;
  logic unused_addr;

  assign ram_idx   = addr[ADDR_WIDTH-1:0];
  assign io_sel    = addr[17:16] == 2'b11;
  assign tx_sel    = io_sel && addr[15:0] == 16'h0000;
  assign stat_sel  = io_sel && addr[15:0] == 16'h0004;
  assign fifo_full = count == CNT_FULL;
  assign stat_byte = {{(7-FIFO_LOG){1'b0}}, count};
  assign unused_addr = ^addr;

  assign pop      = !rst && rdy && tx_ready && count != '0;
  assign push_req = !rst && rdy && wr && tx_sel;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = push_req && (!fifo_full || pop);

  assign tx_data  = fifo[rd_ptr];
  assign tx_valid = count != '0;

  always_ff @(posedge clk) begin
    if (!rst && rdy && wr && !io_sel)
      ram[ram_idx] <= din;
    if (push)
      fifo[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout           <= 8'h00;
      io_buffer_full <= 1'b0;
      halt           <= 1'b0;
      overflow       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else if (rdy) begin
      io_buffer_full <= count >= CNT_AFULL;
      if (!wr)
        dout <= io_sel ? (stat_sel ? stat_byte : 8'h00)
                       : ram[ram_idx];
      if (wr && stat_sel)
        halt <= 1'b1;
      if (push_req && !push)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + FIFO_LOG'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_LOG'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (FIFO_LOG+1)'(1);
        2'b01:   count <= count - (FIFO_LOG+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, meaning RAM depth is 2^ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter FIFO_LOG, default 3, meaning the TX FIFO depth is 2^FIFO_LOG bytes.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; 0 freezes all state except reset.
REQ-006 wr  in  1  access type from the initiator: 1 = write byte, 0 = read byte.
REQ-007 addr  in  32  byte address from the initiator, sampled every enabled cycle.
REQ-008 din  in  8  write data.
REQ-009 dout  out  8  registered read data.
REQ-010 io_buffer_full  out  1  backpressure to the initiator.
REQ-011 tx_data  out  8  head byte of the TX FIFO.
REQ-012 tx_valid  out  1  TX FIFO non-empty.
REQ-013 tx_ready  in  1  downstream consumer pops the head when tx_valid=1 and tx_ready=1.
REQ-014 halt  out  1  sticky program-end flag.
REQ-015 overflow  out  1  sticky flag for a dropped IO write.

Function
REQ-016 Address decode SHALL select the IO region when addr[17:16]==2'b11; otherwise it SHALL select RAM at index addr[ADDR_WIDTH-1:0], ignoring higher bits.
REQ-017 RAM write: wr=1 and rdy=1 and RAM selected SHALL write din to the RAM at the clock edge.
REQ-018 RAM read: wr=0 and rdy=1 and RAM selected SHALL load dout with the RAM byte at the edge, so data is visible in the cycle after the address (1-cycle latency).
REQ-019 Read-after-write to the same address in consecutive cycles SHALL return the newly written byte.
REQ-020 IO write to 0x30000 SHALL push din into the TX FIFO when the FIFO is not full.
REQ-021 An IO write to 0x30000 with the FIFO full and no pop in the same cycle SHALL be dropped and SHALL set overflow.
REQ-022 IO write to 0x30004 SHALL set halt; halt SHALL stay set until reset.
REQ-023 Writes to other IO addresses SHALL be ignored.
REQ-024 IO read of 0x30004 SHALL return {(7-FIFO_LOG) zeros, count} in dout with 1-cycle latency, where count is 0..2^FIFO_LOG.
REQ-025 All other IO reads SHALL return 0x00.
REQ-026 The TX FIFO SHALL be a circular buffer with read/write pointers of FIFO_LOG bits that wrap modulo depth, plus a (FIFO_LOG+1)-bit count.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; a simultaneous push and pop when full SHALL be accepted.
REQ-028 A pop when empty SHALL be ignored.
REQ-029 tx_data SHALL equal the byte at the read pointer; tx_valid SHALL be 1 iff count != 0.
REQ-030 io_buffer_full SHALL be registered and SHALL equal 1 in the cycle after count reaches >= depth-2 (almost-full), leaving slack for one in-flight initiator write.
REQ-031 When rdy=0, RAM, FIFO, dout, halt, overflow and io_buffer_full SHALL hold; the tx pop SHALL also be suppressed.
REQ-032 The block SHALL NOT gate reads or writes on io_buffer_full; the initiator is responsible for honouring it.

Reset
REQ-033 While rst=1 at the edge: dout=0x00, io_buffer_full=0, tx_valid=0, count=0, pointers=0, halt=0, overflow=0.
REQ-034 Reset SHALL take effect regardless of rdy.
REQ-035 Reset mid-operation SHALL discard FIFO contents; RAM contents are not reset.

Verification
REQ-036 Write 0xA5 @0x00010, then read 0x00010 next cycle -> dout=0xA5 one cycle after the read address.
REQ-037 Write bytes 0x11..0x14 @0x100..0x103, then read them back-to-back -> dout = 0x11,0x12,0x13,0x14 on consecutive cycles, each lagging its address by 1.
REQ-038 With tx_ready=0, write 'H','i' @0x30000 -> tx_valid=1, tx_data=0x48; read 0x30004 -> dout=0x02; pulse tx_ready -> tx_data=0x69.
REQ-039 With tx_ready=0 and depth 8, push 6 bytes -> io_buffer_full=1 next cycle; push 2 more -> count=8; a 9th push -> dropped, overflow=1; then push+pop in the same cycle -> count stays 8 and data order is preserved across pointer wrap.
REQ-040 Write @0x30004 -> halt=1; hold rdy=0 while toggling wr/addr -> no RAM, FIFO or flag change; assert rst -> halt=0, tx_valid=0, dout=0x00.
